fmul_arbiter: RTL

Round-robin arbiter that shares one registered FP32 multiplier (Fmultiplier, 1-cycle latency) among NREQ requesters in the DNN datapath. It accepts operand pairs over per-requester valid/ready handshakes and drives the granted pair onto the multiplier. It tracks each in-flight operation's requester ID through the multiplier latency and returns the tagged product, plus exception flag, on a shared response bus. Completion and exception counters support layer-level debug.

---
 rtl/fmul_arbiter_if.sv | 29 ++
 rtl/fmul_arbiter.sv | 93 +++++++++
 2 files changed

// File: rtl/fmul_arbiter_if.sv
// Requester handshake, multiplier operand/result and tagged response signals
// for the shared FP32 multiplier arbiter.
interface fmul_arbiter_if #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic [31:0]        mul_a;
  logic [31:0]        mul_b;
  logic [31:0]        mul_result;
  logic               mul_exception;
  logic               rsp_valid;
  logic [ID_W-1:0]    rsp_id;
  logic [31:0]        rsp_result;
  logic               rsp_exception;

  modport master (
    output req_valid, req_a, req_b, mul_result, mul_exception,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_result, rsp_exception
  );

  modport slave (
    input  req_valid, req_a, req_b, mul_result, mul_exception,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_result, rsp_exception
  );
endinterface

// File: rtl/fmul_arbiter.sv
// Round-robin arbiter sharing one registered FP32 multiplier among NREQ requesters,
// tagging each product with its requester ID and counting completions/exceptions.
module fmul_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  fmul_arbiter_if.slave       bus,
  output logic                busy,
  output logic [31:0]         done_count,
  output logic [15:0]         exc_count
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] ptr_next;
  logic [ID_W-1:0] grant_id;
  logic [ID_W-1:0] scan_id;
  logic            grant_valid;
  logic            s1_valid;
  logic [ID_W-1:0] s1_id;

  // First valid requester at or after ptr wins; nothing is granted while in reset.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    scan_id     = '0;
    if (reset_n) begin
      for (int k = 0; k < NREQ; k++) begin
        scan_id = ID_W'((int'(ptr) + k) % NREQ);
        if (!grant_valid && bus.req_valid[scan_id]) begin
          grant_valid = 1'b1;
          grant_id    = scan_id;
        end
      end
    end
  end

  always_comb begin
    ptr_next = (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
  end

  // Idle cycles feed 0*0 so the multiplier never raises a stray exception.
  always_comb begin
    bus.req_ready = '0;
    bus.mul_a     = '0;
    bus.mul_b     = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_valid && grant_id == ID_W'(k)) begin
        bus.req_ready[k] = 1'b1;
        bus.mul_a        = bus.req_a[32*k +: 32];
        bus.mul_b        = bus.req_b[32*k +: 32];
      end
    end
  end

  // The multiplier's own register is never cleared, so its output is only
  // forwarded on the cycle after a real issue.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr               <= '0;
      s1_valid          <= 1'b0;
      s1_id             <= '0;
      bus.rsp_valid     <= 1'b0;
      bus.rsp_id        <= '0;
      bus.rsp_result    <= '0;
      bus.rsp_exception <= 1'b0;
      done_count        <= '0;
      exc_count         <= '0;
    end else begin
      if (grant_valid) begin
        ptr <= ptr_next;
      end
      s1_valid      <= grant_valid;
      s1_id         <= grant_id;
      bus.rsp_valid <= s1_valid;
      if (s1_valid) begin
        bus.rsp_id        <= s1_id;
        bus.rsp_result    <= bus.mul_result;
        bus.rsp_exception <= bus.mul_exception;
      end
      if (bus.rsp_valid) begin
        done_count <= done_count + 32'd1;
      end
      if (bus.rsp_valid && bus.rsp_exception && exc_count != 16'hFFFF) begin
        exc_count <= exc_count + 16'd1;
      end
    end
  end

  assign busy = s1_valid | bus.rsp_valid;

endmodule
